// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, requester
// indices and the access-counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Bit positions of each requester in request/grant vectors
    localparam int REQ_LD = 0;
    localparam int REQ_IF = 1;
    localparam int REQ_DM = 2;

    // The access counter runs 0..lat, so it needs enough bits to hold lat
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the memory macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              ReqLD;
    logic [ADDR_W-1:0] AddrLD;
    logic [DATA_W-1:0] WDataLD;
    logic              AckLD;
    logic              ReqIF;
    logic [ADDR_W-1:0] AddrIF;
    logic              AckIF;
    logic              ReqDM;
    logic              WeDM;
    logic [ADDR_W-1:0] AddrDM;
    logic [DATA_W-1:0] WDataDM;
    logic              AckDM;
    logic [DATA_W-1:0] RData;
    logic              Busy;
    logic              MemEn;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;

    // Arbiter side
    modport slave (
        input  ReqLD, AddrLD, WDataLD, ReqIF, AddrIF,
        input  ReqDM, WeDM, AddrDM, WDataDM, MemRData,
        output AckLD, AckIF, AckDM, RData, Busy,
        output MemEn, MemWe, MemAddr, MemWData
    );

    // Requester / memory side
    modport master (
        output ReqLD, AddrLD, WDataLD, ReqIF, AddrIF,
        output ReqDM, WeDM, AddrDM, WDataDM, MemRData,
        input  AckLD, AckIF, AckDM, RData, Busy,
        input  MemEn, MemWe, MemAddr, MemWData
    );
endinterface

// File: rtl/arb_pick.sv
// Combinational winner select: loader has strict priority, fetch and data
// share by round-robin pointer. Produces a one-hot (or zero) grant.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic       favour_dm,
    output logic [2:0] gnt
);

    // Priority/round-robin selection
    always_comb begin
        gnt = 3'b000;
        if (req[REQ_LD]) begin
            gnt[REQ_LD] = 1'b1;
        end else if (req[REQ_IF] && req[REQ_DM]) begin
            if (favour_dm) begin
                gnt[REQ_DM] = 1'b1;
            end else begin
                gnt[REQ_IF] = 1'b1;
            end
        end else if (req[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end else if (req[REQ_DM]) begin
            gnt[REQ_DM] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises loader, fetch and data accesses onto one fixed-latency memory.
// Each transaction: IDLE (grant+latch) -> ACCESS (MEM_LAT+1 cycles, strobe in
// the first) -> DONE (Ack pulse) -> IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
)
(
    input  logic               Clk,
    input  logic               Reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int               CNT_W    = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        gnt_reg;
    logic              favour_dm_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [2:0]        req;
    logic [2:0]        pick_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              start;
    logic              last_access;

    assign req         = {bus.ReqDM, bus.ReqIF, bus.ReqLD};
    assign start       = (state_reg == ST_IDLE) && (pick_gnt != 3'b000);
    assign last_access = (state_reg == ST_ACCESS) && (cnt_reg == CNT_LAST);

    arb_pick u_pick (
        .req       (req),
        .favour_dm (favour_dm_reg),
        .gnt       (pick_gnt)
    );

    // Route the winner's address/data/write flag to the latch inputs
    always_comb begin
        sel_addr  = bus.AddrIF;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (pick_gnt[REQ_LD]) begin
            sel_addr  = bus.AddrLD;
            sel_wdata = bus.WDataLD;
            sel_we    = 1'b1;
        end else if (pick_gnt[REQ_DM]) begin
            sel_addr  = bus.AddrDM;
            sel_wdata = bus.WDataDM;
            sel_we    = bus.WeDM;
        end
    end

    // FSM state and wait counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic and FSM-decoded outputs
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bus.Busy   = 1'b0;
        bus.MemEn  = 1'b0;
        bus.AckLD  = 1'b0;
        bus.AckIF  = 1'b0;
        bus.AckDM  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ACCESS;
                    cnt_next   = '0;
                end
            end
            ST_ACCESS: begin
                bus.Busy  = 1'b1;
                bus.MemEn = (cnt_reg == '0);
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                bus.Busy   = 1'b1;
                bus.AckLD  = gnt_reg[REQ_LD];
                bus.AckIF  = gnt_reg[REQ_IF];
                bus.AckDM  = gnt_reg[REQ_DM];
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Latch the granted transaction and advance the round-robin pointer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            gnt_reg       <= 3'b000;
            favour_dm_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
        end else if (start) begin
            gnt_reg   <= pick_gnt;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            we_reg    <= sel_we;
            // Loader grants leave the IF/DM fairness pointer untouched
            if (pick_gnt[REQ_IF]) begin
                favour_dm_reg <= 1'b1;
            end else if (pick_gnt[REQ_DM]) begin
                favour_dm_reg <= 1'b0;
            end
        end
    end

    // Capture read data in the final ACCESS cycle; writes keep the old value
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdata_reg <= '0;
        end else if (last_access && !we_reg) begin
            rdata_reg <= bus.MemRData;
        end
    end

    assign bus.MemWe    = we_reg;
    assign bus.MemAddr  = addr_reg;
    assign bus.MemWData = wdata_reg;
    assign bus.RData    = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=2 instance for the main
// scenarios plus MEM_LAT=1 and MEM_LAT=7 instances for latency corners.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   en_a = 0, en_b = 0, en_c = 0;
    int   en_base;
    int   en_base_c;
    logic [2:0] exp3;

    always #5 clk = ~clk;

    mem_port_arbiter_if ia ();
    mem_port_arbiter_if ib ();
    mem_port_arbiter_if ic ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut_a (.Clk(clk), .Reset(rst), .bus(ia.slave));
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_b (.Clk(clk), .Reset(rst), .bus(ib.slave));
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(7)) dut_c (.Clk(clk), .Reset(rst), .bus(ic.slave));

    // Memory content: 0x0010 holds 0xBEEF, everything else is addr ^ 0xA5A5
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    // Fixed-latency memory models; 0xDEAD marks cycles with no valid data
    logic [15:0] pa [0:1];
    logic [15:0] pb [0:0];
    logic [15:0] pc [0:6];
    always @(posedge clk) begin
        pa[0] <= ia.MemEn ? mem_f(ia.MemAddr) : 16'hDEAD;
        pa[1] <= pa[0];
        pb[0] <= ib.MemEn ? mem_f(ib.MemAddr) : 16'hDEAD;
        pc[0] <= ic.MemEn ? mem_f(ic.MemAddr) : 16'hDEAD;
        for (int i = 1; i < 7; i++) pc[i] <= pc[i-1];
    end
    assign ia.MemRData = pa[1];
    assign ib.MemRData = pb[0];
    assign ic.MemRData = pc[6];

    // Strobe counters
    always @(posedge clk) begin
        if (ia.MemEn === 1'b1) en_a <= en_a + 1;
        if (ib.MemEn === 1'b1) en_b <= en_b + 1;
        if (ic.MemEn === 1'b1) en_c <= en_c + 1;
    end

    // One line per completed transaction
    always @(negedge clk) begin
        if (ia.AckLD || ia.AckIF || ia.AckDM)
            $display("txn dut_a ld=%0b if=%0b dm=%0b rdata=%h", ia.AckLD, ia.AckIF, ia.AckDM, ia.RData);
        if (ib.AckIF) $display("txn dut_b if rdata=%h", ib.RData);
        if (ic.AckIF) $display("txn dut_c if rdata=%h", ic.RData);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.ReqLD = 0; ia.AddrLD = '0; ia.WDataLD = '0; ia.ReqIF = 0; ia.AddrIF = '0;
        ia.ReqDM = 0; ia.WeDM = 0; ia.AddrDM = '0; ia.WDataDM = '0;
        ib.ReqLD = 0; ib.AddrLD = '0; ib.WDataLD = '0; ib.ReqIF = 0; ib.AddrIF = '0;
        ib.ReqDM = 0; ib.WeDM = 0; ib.AddrDM = '0; ib.WDataDM = '0;
        ic.ReqLD = 0; ic.AddrLD = '0; ic.WDataLD = '0; ic.ReqIF = 0; ic.AddrIF = '0;
        ic.ReqDM = 0; ic.WeDM = 0; ic.AddrDM = '0; ic.WDataDM = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_ctrl_a", {ia.Busy, ia.MemEn, ia.MemWe, ia.AckLD, ia.AckIF, ia.AckDM}, 0);
        chk("rst_addr_a", ia.MemAddr, 16'h0000);
        chk("rst_wdata_a", ia.MemWData, 16'h0000);
        chk("rst_rdata_a", ia.RData, 16'h0000);
        chk("rst_ctrl_b", {ib.Busy, ib.MemEn, ib.AckIF}, 0);
        chk("rst_ctrl_c", {ic.Busy, ic.MemEn, ic.AckIF}, 0);

        // Single fetch, MEM_LAT=2
        en_base = en_a;
        ia.ReqIF = 1; ia.AddrIF = 16'h0010;
        chk("if_c0_busy", ia.Busy, 1'b0);
        step();
        chk("if_c1_en", ia.MemEn, 1'b1);
        chk("if_c1_addr", ia.MemAddr, 16'h0010);
        chk("if_c1_we", ia.MemWe, 1'b0);
        chk("if_c1_busy", ia.Busy, 1'b1);
        step();
        chk("if_c2_en", ia.MemEn, 1'b0);
        chk("if_c2_addr", ia.MemAddr, 16'h0010);
        step();
        chk("if_c3_ack", ia.AckIF, 1'b0);
        chk("if_c3_busy", ia.Busy, 1'b1);
        step();
        chk("if_c4_ack", ia.AckIF, 1'b1);
        chk("if_c4_rdata", ia.RData, 16'hBEEF);
        chk("if_c4_busy", ia.Busy, 1'b1);
        ia.ReqIF = 0;
        step();
        chk("if_c5_busy", ia.Busy, 1'b0);
        chk("if_c5_ack", ia.AckIF, 1'b0);
        chk("if_en_count", en_a - en_base, 1);

        // Data write
        en_base = en_a;
        ia.ReqDM = 1; ia.WeDM = 1; ia.AddrDM = 16'h0200; ia.WDataDM = 16'h1234;
        step();
        chk("wr_c1_en", ia.MemEn, 1'b1);
        chk("wr_c1_we", ia.MemWe, 1'b1);
        chk("wr_c1_addr", ia.MemAddr, 16'h0200);
        chk("wr_c1_wdata", ia.MemWData, 16'h1234);
        step();
        step();
        chk("wr_c3_ack", ia.AckDM, 1'b0);
        step();
        chk("wr_c4_ack", {ia.AckLD, ia.AckIF, ia.AckDM}, 3'b001);
        chk("wr_c4_rdata", ia.RData, 16'hBEEF);
        ia.ReqDM = 0; ia.WeDM = 0;
        step();
        chk("wr_en_count", en_a - en_base, 1);

        // All three requesting: LD, IF, DM in order
        ia.ReqLD = 1; ia.AddrLD = 16'h0300; ia.WDataLD = 16'h5555;
        ia.ReqIF = 1; ia.AddrIF = 16'h0010;
        ia.ReqDM = 1; ia.WeDM = 0; ia.AddrDM = 16'h0040;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            step();
            exp3 = (cyc == 4) ? 3'b100 : (cyc == 9) ? 3'b010 : (cyc == 14) ? 3'b001 : 3'b000;
            chk("order_acks", {ia.AckLD, ia.AckIF, ia.AckDM}, exp3);
            if (cyc == 1) begin
                chk("order_ld_addr", ia.MemAddr, 16'h0300);
                chk("order_ld_we", ia.MemWe, 1'b1);
                chk("order_ld_wdata", ia.MemWData, 16'h5555);
            end
            if (cyc == 6)  chk("order_if_addr", ia.MemAddr, 16'h0010);
            if (cyc == 11) chk("order_dm_addr", ia.MemAddr, 16'h0040);
            if (cyc == 9)  chk("order_if_rdata", ia.RData, 16'hBEEF);
            if (cyc == 14) chk("order_dm_rdata", ia.RData, 16'hA5E5);
            if (ia.AckLD) ia.ReqLD = 0;
            if (ia.AckIF) ia.ReqIF = 0;
            if (ia.AckDM) ia.ReqDM = 0;
        end

        // IF and DM held continuously: grants alternate
        ia.ReqIF = 1; ia.AddrIF = 16'h0010;
        ia.ReqDM = 1; ia.WeDM = 0; ia.AddrDM = 16'h0080;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step();
            exp3 = (cyc == 4 || cyc == 14) ? 3'b010 : (cyc == 9 || cyc == 19) ? 3'b001 : 3'b000;
            chk("rr_acks", {ia.AckLD, ia.AckIF, ia.AckDM}, exp3);
            if (cyc == 9) chk("rr_dm_rdata", ia.RData, 16'hA525);
            if (cyc == 14) chk("rr_if_rdata", ia.RData, 16'hBEEF);
            if (cyc == 19) begin
                ia.ReqIF = 0;
                ia.ReqDM = 0;
            end
        end

        // Reset during ACCESS of a read abandons it
        ia.ReqIF = 1; ia.AddrIF = 16'h0010;
        step();
        chk("mrst_c1_en", ia.MemEn, 1'b1);
        rst = 1'b1;
        ia.ReqIF = 0;
        step();
        rst = 1'b0;
        chk("mrst_ctrl", {ia.Busy, ia.MemEn, ia.MemWe, ia.AckLD, ia.AckIF, ia.AckDM}, 0);
        chk("mrst_addr", ia.MemAddr, 16'h0000);
        chk("mrst_rdata", ia.RData, 16'h0000);
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            chk("mrst_no_ack", {ia.Busy, ia.AckLD, ia.AckIF, ia.AckDM}, 0);
            chk("mrst_rdata_hold", ia.RData, 16'h0000);
        end
        ia.ReqIF = 1; ia.AddrIF = 16'h0020;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            step();
            chk("mrst_fresh_ack", ia.AckIF, (cyc == 4) ? 1'b1 : 1'b0);
            if (cyc == 4) begin
                chk("mrst_fresh_rdata", ia.RData, 16'hA585);
                ia.ReqIF = 0;
            end
        end

        // Latency corners: MEM_LAT=1 (Ack at 3) and MEM_LAT=7 (Ack at 9)
        en_base = en_b;
        en_base_c = en_c;
        ib.ReqIF = 1; ib.AddrIF = 16'h0010;
        ic.ReqIF = 1; ic.AddrIF = 16'h0010;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            chk("lat1_ack", ib.AckIF, (cyc == 3) ? 1'b1 : 1'b0);
            chk("lat7_ack", ic.AckIF, (cyc == 9) ? 1'b1 : 1'b0);
            if (cyc == 3) chk("lat1_rdata", ib.RData, 16'hBEEF);
            if (cyc == 9) chk("lat7_rdata", ic.RData, 16'hBEEF);
            if (ib.AckIF) ib.ReqIF = 0;
            if (ic.AckIF) ic.ReqIF = 0;
        end
        chk("lat1_en_count", en_b - en_base, 1);
        chk("lat7_en_count", en_c - en_base_c, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
